// File: rtl/score_pkg.sv
// Shared types and helpers for the score tracker: FSM state enum, BCD digit width,
// and a saturating adder.
package score_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, OVER, WIN} score_state_t;

    localparam int DIGIT_W = 4;

    // The sum is formed one bit wider than the result, so it cannot wrap before it is clamped.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << width) - 33'd1;
        return (sum > max_v) ? max_v[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble converter. It uses one load cycle and then IN_W shift cycles.
// A start pulse aborts any conversion in flight, and bcd holds the last finished result.
module bcd_seq_conv
    import score_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [IN_W-1:0]               bin,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
    output logic                          busy
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  shift_reg;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        adj = acc;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (acc[d*DIGIT_W +: DIGIT_W] >= 4'd5)
                adj[d*DIGIT_W +: DIGIT_W] = acc[d*DIGIT_W +: DIGIT_W] + 4'd3;
        end
        acc_next = {adj[BCD_W-2:0], shift_reg[IN_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            shift_reg <= bin;
            acc       <= '0;
            cnt       <= CNT_W'(IN_W);
            busy      <= 1'b1;
        end else if (busy) begin
            shift_reg <= shift_reg << 1;
            acc       <= acc_next;
            cnt       <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                bcd  <= acc_next;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/score_tracker_param.sv
// Score tracker. It keeps the running score, the session high score and the win/over
// state, and feeds a BCD display. Defining SCORE_TRACKER_LEVEL_EN adds the level and
// level_up outputs.
module score_tracker_param
    import score_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int NUM_DIGITS = 3,
    parameter int PTS_W      = 2,
    parameter int WIN_SCORE  = 100,
    parameter int LEVEL_STEP = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          goodColl,
    input  logic [PTS_W-1:0]              pts,
    input  logic                          badColl,
    output logic [SCORE_W-1:0]            current_score,
    output logic [SCORE_W-1:0]            high_score,
    output logic [SCORE_W-1:0]            dispScore,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_digits,
    output logic                          bcd_valid,
    output logic                          isGameComplete,
    output logic                          game_over
`ifdef SCORE_TRACKER_LEVEL_EN
    ,
    output logic [7:0]                    level,
    output logic                          level_up
`endif
);

    score_state_t       state;
    score_state_t       state_n;
    logic [SCORE_W-1:0] eff_pts;
    logic [SCORE_W-1:0] cur_n;
    logic [SCORE_W-1:0] high_n;
    logic [SCORE_W-1:0] disp_n;
    logic               new_game;
    logic               add_pts;
    logic               conv_busy;

    // NOTE: every output gets a default before the case, so this block cannot infer a latch.
    always_comb begin
        eff_pts  = (pts == '0) ? SCORE_W'(1) : SCORE_W'(pts);
        state_n  = state;
        cur_n    = current_score;
        high_n   = high_score;
        new_game = 1'b0;
        add_pts  = 1'b0;
        case (state)
            PLAY: begin
                if (badColl) begin
                    state_n = OVER;
                    high_n  = (current_score > high_score) ? current_score : high_score;
                end else if (goodColl) begin
                    add_pts = 1'b1;
                    cur_n   = SCORE_W'(sat_add(32'(current_score), 32'(eff_pts), SCORE_W));
                    if (32'(cur_n) >= WIN_SCORE) begin
                        state_n = WIN;
                        high_n  = (cur_n > high_score) ? cur_n : high_score;
                    end
                end
            end
            IDLE, OVER, WIN: new_game = goodColl;
            default: state_n = IDLE;
        endcase
        if (new_game) begin
            cur_n   = eff_pts;
            state_n = PLAY;
        end
        disp_n = (state_n == OVER || state_n == WIN) ? high_n : cur_n;
    end

    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            current_score <= '0;
            high_score    <= '0;
            dispScore     <= '0;
        end else begin
            state         <= state_n;
            current_score <= cur_n;
            high_score    <= high_n;
            dispScore     <= disp_n;
        end
    end

    assign isGameComplete = (state == WIN);
    assign game_over      = (state == OVER);
    assign bcd_valid      = ~conv_busy;

    // The converter loads on the same edge that dispScore changes, so bcd_valid drops immediately.
    bcd_seq_conv #(
        .IN_W       (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (disp_n != dispScore),
        .bin   (disp_n),
        .bcd   (bcd_digits),
        .busy  (conv_busy)
    );

`ifdef SCORE_TRACKER_LEVEL_EN
    // The remainder tracks current_score mod LEVEL_STEP. One apple is assumed to be worth less than a step.
    logic [SCORE_W:0] rem;
    logic [SCORE_W:0] rem_sum;

    always_comb begin
        rem_sum = new_game ? {1'b0, cur_n} : rem + {1'b0, cur_n - current_score};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= '0;
            rem      <= '0;
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (new_game || add_pts) begin
                if (32'(rem_sum) >= LEVEL_STEP) begin
                    level    <= new_game ? 8'd1 : level + 8'd1;
                    rem      <= rem_sum - (SCORE_W+1)'(LEVEL_STEP);
                    level_up <= 1'b1;
                end else begin
                    level <= new_game ? 8'd0 : level;
                    rem   <= rem_sum;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_score_tracker_param.sv
// Self-checking bench for score_tracker_param: hand-computed vectors, corner sequences,
// and randomized play against a behavioural model.
module tb_score_tracker_param;

    localparam int SW  = 8;
    localparam int ND  = 3;
    localparam int PW  = 2;
    localparam int WS  = 100;
    localparam int SW2 = 4;
    localparam int ND2 = 2;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    localparam int M_WON  = 3;

    logic          clk;
    logic          rst;
    logic          goodColl;
    logic [PW-1:0] pts;
    logic          badColl;
    logic [SW-1:0] current_score;
    logic [SW-1:0] high_score;
    logic [SW-1:0] dispScore;
    logic [4*ND-1:0] bcd_digits;
    logic          bcd_valid;
    logic          isGameComplete;
    logic          game_over;

    logic          good2;
    logic [PW-1:0] pts2;
    logic          bad2;
    logic [SW2-1:0] cur2;
    logic [SW2-1:0] high2;
    logic [SW2-1:0] disp2;
    logic [4*ND2-1:0] bcd2;
    logic          valid2;
    logic          win2;
    logic          over2;
`ifdef SCORE_TRACKER_LEVEL_EN
    logic [7:0]    level;
    logic          level_up;
    logic [7:0]    level2;
    logic          level_up2;
`endif

    score_tracker_param #(.SCORE_W(SW), .NUM_DIGITS(ND), .PTS_W(PW), .WIN_SCORE(WS), .LEVEL_STEP(10)) dut (
        .clk(clk), .rst(rst), .goodColl(goodColl), .pts(pts), .badColl(badColl),
        .current_score(current_score), .high_score(high_score), .dispScore(dispScore),
        .bcd_digits(bcd_digits), .bcd_valid(bcd_valid), .isGameComplete(isGameComplete),
        .game_over(game_over)
`ifdef SCORE_TRACKER_LEVEL_EN
        , .level(level), .level_up(level_up)
`endif
    );

    score_tracker_param #(.SCORE_W(SW2), .NUM_DIGITS(ND2), .PTS_W(PW), .WIN_SCORE(WS), .LEVEL_STEP(10)) dut_sat (
        .clk(clk), .rst(rst), .goodColl(good2), .pts(pts2), .badColl(bad2),
        .current_score(cur2), .high_score(high2), .dispScore(disp2),
        .bcd_digits(bcd2), .bcd_valid(valid2), .isGameComplete(win2),
        .game_over(over2)
`ifdef SCORE_TRACKER_LEVEL_EN
        , .level(level2), .level_up(level_up2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the game rules and the display/BCD timing.
    int          m_mode;
    int          m_score;
    int          m_high;
    int          m_disp;
    int          m_left;
    logic [11:0] m_bcd;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_score = 0; m_high = 0; m_disp = 0; m_left = 0; m_bcd = '0;
    endtask

    task automatic model_step(input bit g, input int p, input bit b);
        int eff = (p == 0) ? 1 : p;
        int nd;
        case (m_mode)
            M_PLAY: begin
                if (b) begin
                    if (m_score > m_high) m_high = m_score;
                    m_mode = M_OVER;
                end else if (g) begin
                    m_score = m_score + eff;
                    if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
                    if (m_score >= WS) begin
                        m_mode = M_WON;
                        if (m_score > m_high) m_high = m_score;
                    end
                end
            end
            default: begin
                if (g) begin
                    m_score = eff;
                    m_mode  = M_PLAY;
                end
            end
        endcase
        nd = (m_mode == M_OVER || m_mode == M_WON) ? m_high : m_score;
        if (nd != m_disp) m_left = SW;
        else if (m_left > 0) m_left--;
        m_disp = nd;
        if (m_left == 0) m_bcd = to_bcd(m_disp);
    endtask

    task automatic check_all();
        check("current_score", 32'(current_score), 32'(m_score));
        check("high_score", 32'(high_score), 32'(m_high));
        check("dispScore", 32'(dispScore), 32'(m_disp));
        check("bcd_valid", 32'(bcd_valid), 32'(m_left == 0));
        check("bcd_digits", 32'(bcd_digits), 32'(m_bcd));
        check("isGameComplete", 32'(isGameComplete), 32'(m_mode == M_WON));
        check("game_over", 32'(game_over), 32'(m_mode == M_OVER));
    endtask

    task automatic step(input bit g, input logic [PW-1:0] p, input bit b);
        goodColl = g; pts = p; badColl = b;
        @(posedge clk);
        model_step(g, int'(p), b);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        goodColl = 0; pts = '0; badColl = 0; good2 = 0; pts2 = '0; bad2 = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    typedef struct {
        bit   r;
        bit   g;
        logic [PW-1:0] p;
        bit   b;
        int   cur;
        int   high;
        int   disp;
        bit   over;
        bit   win;
        int   idle;
        int   bcd;
    } vec_t;

    vec_t vecs[$];

    task automatic check_vec(input vec_t v);
        check("vec current_score", 32'(current_score), 32'(v.cur));
        check("vec high_score", 32'(high_score), 32'(v.high));
        check("vec dispScore", 32'(dispScore), 32'(v.disp));
        check("vec game_over", 32'(game_over), 32'(v.over));
        check("vec isGameComplete", 32'(isGameComplete), 32'(v.win));
    endtask

    initial begin
        int exp2;
        int budget;
        rst = 1'b1; goodColl = 0; pts = '0; badColl = 0; good2 = 0; pts2 = '0; bad2 = 0;
        model_reset();

        //          r  g  p  b  cur high disp ov win idle bcd
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000});
        vecs.push_back('{0, 1, 1, 0, 1, 0, 1, 0, 0, 0, -1});
        vecs.push_back('{0, 1, 2, 0, 3, 0, 3, 0, 0, 0, -1});
        vecs.push_back('{0, 1, 0, 0, 4, 0, 4, 0, 0, 8, 'h004});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000});
        vecs.push_back('{0, 1, 2, 0, 2, 0, 2, 0, 0, 0, -1});
        vecs.push_back('{0, 0, 0, 1, 2, 2, 2, 1, 0, 8, 'h002});
        vecs.push_back('{0, 1, 2, 0, 2, 2, 2, 0, 0, 0, -1});
        vecs.push_back('{0, 1, 2, 0, 4, 2, 4, 0, 0, 0, -1});
        vecs.push_back('{0, 0, 0, 1, 4, 4, 4, 1, 0, 5, -1});
        vecs.push_back('{0, 1, 1, 0, 1, 4, 1, 0, 0, 0, -1});
        vecs.push_back('{0, 0, 0, 1, 1, 4, 4, 1, 0, 8, 'h004});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000});
        vecs.push_back('{0, 1, 3, 0, 3, 0, 3, 0, 0, 0, -1});
        vecs.push_back('{0, 1, 2, 0, 5, 0, 5, 0, 0, 0, -1});
        vecs.push_back('{0, 1, 1, 1, 5, 5, 5, 1, 0, 8, 'h005});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].r) do_reset();
            else step(vecs[i].g, vecs[i].p, vecs[i].b);
            check_vec(vecs[i]);
            for (int k = 0; k < vecs[i].idle; k++) step(0, '0, 0);
            if (vecs[i].idle > 0) check_vec(vecs[i]);
            if (vecs[i].bcd >= 0) begin
                check("vec bcd_valid", 32'(bcd_valid), 32'd1);
                check("vec bcd_digits", 32'(bcd_digits), 32'(vecs[i].bcd));
            end
        end

        // Reach the win threshold one point at a time.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1, 2'd1, 0);
            if (i == 98) check("win before 100th", 32'(isGameComplete), 32'd0);
        end
        check("win after 100th", 32'(isGameComplete), 32'd1);
        check("win dispScore", 32'(dispScore), 32'd100);
        check("win high_score", 32'(high_score), 32'd100);
        budget = 0;
        while (!bcd_valid && budget < 20) begin
            step(0, '0, 0);
            budget++;
        end
        check("win bcd wait in budget", 32'(budget < 20), 32'd1);
        check("win bcd_digits", 32'(bcd_digits), 32'h100);
        step(0, '0, 1);
        check("win ignores badColl", 32'(isGameComplete), 32'd1);

        // A 4-bit score saturates at 15.
        do_reset();
        exp2 = 0;
        for (int i = 0; i < 7; i++) begin
            good2 = 1; pts2 = 2'd3;
            @(posedge clk);
            #1;
            exp2 = (exp2 + 3 > 15) ? 15 : exp2 + 3;
            check("sat current_score", 32'(cur2), 32'(exp2));
        end
        good2 = 0; pts2 = '0;

        // Reset in the middle of a conversion.
        do_reset();
        step(1, 2'd3, 0);
        step(0, '0, 0);
        step(0, '0, 0);
        check("busy before reset", 32'(bcd_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid-conv rst bcd_valid", 32'(bcd_valid), 32'd1);
        check("mid-conv rst bcd_digits", 32'(bcd_digits), 32'd0);
        check("mid-conv rst current_score", 32'(current_score), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Randomized play: frequent deaths, then long runs that reach WIN.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step(($urandom % 3) == 0, PW'($urandom), ($urandom % 12) == 0);
        for (int i = 0; i < 2000; i++)
            step(($urandom % 4) != 0, PW'($urandom), ($urandom % 90) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
